fsb_client_arbiter: RTL and testbench
=====================================

Name: fsb_client_arbiter

Overview:
- Shares the single 80-bit FSB master port of the host adapter among num_clients_p CL-side FSB clients.
- Upstream (client→host): round-robin arbitration, tags each packet with the winning client index, buffers it in a 2-entry output FIFO.
- Downstream (host→client): routes each packet to the client named in its id field through a 1-entry register stage.
- Packets with an out-of-range id are dropped and counted.

Parameters:
fsb_width_p, 80, FSB packet width in bits (one packet = one beat)
num_clients_p, 4, number of clients; legal range 2..16
id_lsb_p, 76, LSB of the client-id field inside a packet; field width lg_clients_lp = clog2(num_clients_p)
drop_cnt_width_p, 8, width of the saturating drop counter

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, synchronous, active-low
m_fsb_v_o  out  1  upstream packet valid, to host adapter
m_fsb_data_o  out  fsb_width_p  upstream packet
m_fsb_r_i  in  1  host adapter ready
m_fsb_v_i  in  1  downstream packet valid, from host adapter
m_fsb_data_i  in  fsb_width_p  downstream packet
m_fsb_r_o  out  1  ready to host adapter
c_v_i  in  num_clients_p  per-client upstream valid
c_data_i  in  num_clients_p*fsb_width_p  per-client upstream packets; client k in slice k
c_r_o  out  num_clients_p  per-client upstream ready (one-hot or zero)
c_v_o  out  num_clients_p  per-client downstream valid (one-hot or zero)
c_data_o  out  fsb_width_p  downstream packet, shared by all clients
c_r_i  in  num_clients_p  per-client downstream ready
drop_cnt_o  out  drop_cnt_width_p  count of dropped downstream packets, saturating
drop_err_o  out  1  sticky: at least one packet dropped

Behaviour:
- Reset: all state is cleared when reset_n_i is low on a rising clk_i edge.
  - Output FIFO empty, so m_fsb_v_o=0.
  - Downstream register empty, so c_v_o=0.
  - drop_cnt_o=0, drop_err_o=0.
  - Round-robin last-winner pointer = num_clients_p-1, so client 0 has top priority after reset.
  - While reset is asserted: c_r_o=0 and m_fsb_r_o=0.
  - Reset mid-transfer discards buffered packets; no partial state survives.
- Upstream arbitration:
  - Each cycle, if the FIFO has a free slot (count<2, or count==2 with a pop this cycle), grant the first requesting client after the last-winner pointer, wrapping modulo num_clients_p.
  - c_r_o is one-hot to the winner only; it depends combinationally on c_v_i.
  - Transfer occurs on c_v_i[k]&c_r_o[k]. The pointer then updates to k; with no transfer the pointer holds.
  - Pushed packet = c_data_i slice k, with bits [id_lsb_p +: lg_clients_lp] overwritten by k.
  - Latency: a packet accepted in cycle N appears on m_fsb_v_o/m_fsb_data_o in cycle N+1 if the FIFO was empty.
  - m_fsb_v_o = FIFO not empty; m_fsb_data_o = FIFO head. Pop on m_fsb_v_o&m_fsb_r_i.
  - Simultaneous push and pop at count 2 is allowed; count stays 2.
  - Full FIFO with no pop: c_r_o=0.
  - Sustained throughput is 1 packet/cycle when m_fsb_r_i is held high.
- Downstream routing:
  - Register holds one packet plus its decoded id.
  - c_v_o[id] = register valid; c_data_o = register data.
  - Drain on c_v_o[id]&c_r_i[id].
  - m_fsb_r_o = register empty OR draining this cycle (1 packet/cycle pass-through).
  - Accept on m_fsb_v_i&m_fsb_r_o; the packet is visible to the client the next cycle.
  - If the incoming id >= num_clients_p: the packet is still accepted but not stored; drop_cnt_o increments (saturating at all-ones) and drop_err_o is set until reset.
  - A register that is not drained holds its data stable, and m_fsb_r_o stays 0.
- Upstream and downstream paths are independent and may transfer in the same cycle.

Test Plan:
- Reset: hold reset_n_i=0 for 3 cycles with all c_v_i=1 → m_fsb_v_o=0, c_r_o=0, m_fsb_r_o=0, drop_cnt_o=0. First cycle after release: c_r_o=4'b0001.
- Round-robin fairness: c_v_i=4'b1111 held for 8 cycles, m_fsb_r_i=1 → grant order 0,1,2,3,0,1,2,3. m_fsb_data_o id field sequence 0,1,2,3,…, starting one cycle after the first grant.
- Backpressure: m_fsb_r_i=0, c_v_i=4'b0100 → two packets accepted in cycles 1-2, then c_r_o=0. Raise m_fsb_r_i → both packets emerge in order, then flow resumes at 1 packet/cycle.
- Id tagging: client 2 sends data with id field 3 → m_fsb_data_o id field = 2, all other bits unchanged.
- Downstream routing: host sends id 1 then id 3 back-to-back with c_r_i=4'b1111 → c_v_o=4'b0010 then 4'b1000 on consecutive cycles, m_fsb_r_o held 1. With c_r_i[1]=0: m_fsb_r_o=0 and data held until c_r_i[1]=1.
- Drop path: num_clients_p=3, host sends id 3 → m_fsb_r_o=1, c_v_o stays 0, drop_cnt_o=1, drop_err_o=1. Send 300 such packets → drop_cnt_o saturates at 255.

Source files
------------

// File: rtl/fsb_client_arbiter.sv
// Shares one FSB master port among several CL clients: round-robin upstream into a
// 2-entry FIFO with client tagging, id-routed downstream through a 1-entry register.
module fsb_client_arbiter #(
    parameter int fsb_width_p      = 80,
    parameter int num_clients_p    = 4,
    parameter int id_lsb_p         = 76,
    parameter int drop_cnt_width_p = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    output logic                                 m_fsb_v_o,
    output logic [fsb_width_p-1:0]               m_fsb_data_o,
    input  logic                                 m_fsb_r_i,
    input  logic                                 m_fsb_v_i,
    input  logic [fsb_width_p-1:0]               m_fsb_data_i,
    output logic                                 m_fsb_r_o,
    input  logic [num_clients_p-1:0]             c_v_i,
    input  logic [num_clients_p*fsb_width_p-1:0] c_data_i,
    output logic [num_clients_p-1:0]             c_r_o,
    output logic [num_clients_p-1:0]             c_v_o,
    output logic [fsb_width_p-1:0]               c_data_o,
    input  logic [num_clients_p-1:0]             c_r_i,
    output logic [drop_cnt_width_p-1:0]          drop_cnt_o,
    output logic                                 drop_err_o
);
    localparam int lg_clients_lp = $clog2(num_clients_p);

    logic [fsb_width_p-1:0]   fifo_q [2];
    logic                     fifo_rd_q, fifo_wr_q;
    logic [1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [lg_clients_lp-1:0] last_q, win, cand;
    logic [31:0]              idx;
    logic                     found, pop, push, free;
    logic [fsb_width_p-1:0]   push_data;

    assign m_fsb_v_o    = (fifo_cnt_q != 2'd0);
    assign m_fsb_data_o = fifo_q[fifo_rd_q];
    assign pop          = m_fsb_v_o & m_fsb_r_i;
    assign free         = reset_n_i & ((fifo_cnt_q != 2'd2) | pop);
    assign push         = free & found;

    // Scan clients starting just after the last winner, wrapping modulo num_clients_p.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= num_clients_p; i++) begin
            idx  = (32'(last_q) + i) % 32'(num_clients_p);
            cand = lg_clients_lp'(idx);
            if (!found && c_v_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        c_r_o = '0;
        if (push) c_r_o[win] = 1'b1;
        push_data = c_data_i[win*fsb_width_p +: fsb_width_p];
        push_data[id_lsb_p +: lg_clients_lp] = win;
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // At count 2 a push lands in the slot being popped; the pop reads the old value.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= '0;
            last_q     <= lg_clients_lp'(num_clients_p - 1);
        end else begin
            if (push) begin
                fifo_q[fifo_wr_q] <= push_data;
                fifo_wr_q         <= ~fifo_wr_q;
                last_q            <= win;
            end
            if (pop) fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    logic                        ds_v_q;
    logic [lg_clients_lp-1:0]    ds_id_q, in_id;
    logic [fsb_width_p-1:0]      ds_data_q;
    logic [drop_cnt_width_p-1:0] drop_cnt_q;
    logic                        drop_err_q;
    logic                        drain, accept, in_range;

    assign in_id     = m_fsb_data_i[id_lsb_p +: lg_clients_lp];
    assign in_range  = ({1'b0, in_id} < (lg_clients_lp+1)'(num_clients_p));
    assign drain     = ds_v_q & c_r_i[ds_id_q];
    assign m_fsb_r_o = reset_n_i & (~ds_v_q | drain);
    assign accept    = m_fsb_v_i & m_fsb_r_o;

    always_comb begin
        c_v_o = '0;
        if (ds_v_q) c_v_o[ds_id_q] = 1'b1;
    end

    assign c_data_o   = ds_data_q;
    assign drop_cnt_o = drop_cnt_q;
    assign drop_err_o = drop_err_q;

    // Out-of-range ids are accepted but never stored, so a drain and a drop can coincide.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ds_v_q     <= 1'b0;
            ds_id_q    <= '0;
            ds_data_q  <= '0;
            drop_cnt_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            if (accept && in_range) begin
                ds_v_q    <= 1'b1;
                ds_id_q   <= in_id;
                ds_data_q <= m_fsb_data_i;
            end else if (drain) begin
                ds_v_q <= 1'b0;
            end
            if (accept && !in_range) begin
                drop_err_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fsb_client_arbiter.sv
// Randomised scoreboard bench for fsb_client_arbiter with a queue-based reference model;
// a second 3-client instance covers the out-of-range drop path.
module tb_fsb_client_arbiter;
    localparam int W = 80, N = 4, LSB = 76, DW = 8, LG = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             m_v_o, m_r_i, h_v, m_r_o, derr;
    logic [W-1:0]     m_d_o, h_d, c_d_o;
    logic [N-1:0]     c_v_i, c_r_o, c_v_o, c_r_i;
    logic [N*W-1:0]   c_d_i;
    logic [DW-1:0]    dcnt;

    logic             m_v_o3, h_v3, m_r_o3, derr3;
    logic [W-1:0]     m_d_o3, h_d3, c_d_o3;
    logic [2:0]       c_r_o3, c_v_o3, c_r_i3;
    logic [3*W-1:0]   c_d_i3;
    logic [DW-1:0]    dcnt3;

    fsb_client_arbiter #(.fsb_width_p(W), .num_clients_p(N), .id_lsb_p(LSB), .drop_cnt_width_p(DW)) u_dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .m_fsb_v_o(m_v_o), .m_fsb_data_o(m_d_o), .m_fsb_r_i(m_r_i),
        .m_fsb_v_i(h_v), .m_fsb_data_i(h_d), .m_fsb_r_o(m_r_o),
        .c_v_i(c_v_i), .c_data_i(c_d_i), .c_r_o(c_r_o),
        .c_v_o(c_v_o), .c_data_o(c_d_o), .c_r_i(c_r_i),
        .drop_cnt_o(dcnt), .drop_err_o(derr)
    );

    fsb_client_arbiter #(.fsb_width_p(W), .num_clients_p(3), .id_lsb_p(LSB), .drop_cnt_width_p(DW)) u_dut3 (
        .clk_i(clk), .reset_n_i(rst_n),
        .m_fsb_v_o(m_v_o3), .m_fsb_data_o(m_d_o3), .m_fsb_r_i(1'b1),
        .m_fsb_v_i(h_v3), .m_fsb_data_i(h_d3), .m_fsb_r_o(m_r_o3),
        .c_v_i(3'b000), .c_data_i(c_d_i3), .c_r_o(c_r_o3),
        .c_v_o(c_v_o3), .c_data_o(c_d_o3), .c_r_i(c_r_i3),
        .drop_cnt_o(dcnt3), .drop_err_o(derr3)
    );

    int tests = 0, fails = 0;

    typedef struct {
        logic [N-1:0]  grant;
        logic          mv;
        logic          mro;
        logic [N-1:0]  cv;
        logic [W-1:0]  cdata;
        logic [DW-1:0] dcnt;
        logic          derr;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] sb_up[$];

    int           occ, last, ds_id, drop;
    bit           ds_occ;
    logic [W-1:0] ds_data;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return W'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [N*W-1:0] rnd_cd();
        logic [N*W-1:0] v;
        for (int i = 0; i < N*W; i += 32) v[i +: 32] = $urandom();
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("c_r_o", c_r_o, e.grant);
            chk("m_fsb_v_o", m_v_o, e.mv);
            chk("m_fsb_r_o", m_r_o, e.mro);
            chk("c_v_o", c_v_o, e.cv);
            if (e.cv != '0) chk("c_data_o", c_d_o, e.cdata);
            chk("drop_cnt_o", dcnt, e.dcnt);
            chk("drop_err_o", derr, e.derr);
            if (m_v_o && m_r_i) begin
                if (sb_up.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL m_fsb_data_o: got %0h expected no packet at %0t", m_d_o, $time);
                end else begin
                    chk("m_fsb_data_o", m_d_o, sb_up.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; the model predicts this cycle's outputs and next state.
    task automatic cycle(input logic [N-1:0] cv, input logic [N*W-1:0] cd, input logic mr,
                         input logic hv, input logic [W-1:0] hd, input logic [N-1:0] cr);
        exp_t         e;
        int           k;
        bit           pop, found;
        logic [W-1:0] pkt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        c_v_i = cv; c_d_i = cd; m_r_i = mr; h_v = hv; h_d = hd; c_r_i = cr;

        pop     = (occ > 0) && mr;
        e.mv    = (occ > 0);
        e.grant = '0;
        found   = 1'b0;
        k       = 0;
        if (occ < 2 || pop)
            for (int i = 1; i <= N; i++)
                if (!found && cv[(last + i) % N]) begin
                    found = 1'b1;
                    k     = (last + i) % N;
                end
        if (found) begin
            e.grant[k] = 1'b1;
            pkt = cd[k*W +: W];
            pkt[LSB +: LG] = LG'(k);
            sb_up.push_back(pkt);
            last = k;
        end
        occ = occ + int'(found) - int'(pop);

        e.cv    = '0;
        e.cdata = ds_data;
        e.dcnt  = DW'(drop);
        e.derr  = (drop > 0);
        if (ds_occ) e.cv[ds_id] = 1'b1;
        e.mro = !ds_occ || cr[ds_id];
        if (ds_occ && cr[ds_id]) ds_occ = 1'b0;
        if (hv && e.mro) begin
            if (int'(hd[LSB +: LG]) < N) begin
                ds_occ  = 1'b1;
                ds_id   = int'(hd[LSB +: LG]);
                ds_data = hd;
            end else if (drop < (1 << DW) - 1) begin
                drop++;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; c_v_i = '1; m_r_i = 1'b1; h_v = 1'b1; h_d = '0; c_r_i = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst m_fsb_v_o", m_v_o, 0);
        chk("rst c_r_o", c_r_o, 0);
        chk("rst m_fsb_r_o", m_r_o, 0);
        chk("rst c_v_o", c_v_o, 0);
        chk("rst drop_cnt_o", dcnt, 0);
        chk("rst drop_err_o", derr, 0);
        chk("rst dut3 drop_cnt_o", dcnt3, 0);
        occ = 0; last = N - 1; sb_up.delete();
        ds_occ = 1'b0; ds_id = 0; drop = 0; ds_data = '0;
    endtask

    initial begin
        logic [N*W-1:0] cd;
        logic [W-1:0]   hd;
        rst_n = 1'b0; c_v_i = '0; c_d_i = '0; m_r_i = 1'b0; h_v = 1'b0; h_d = '0; c_r_i = '0;
        h_v3 = 1'b0; h_d3 = '0; c_d_i3 = '0; c_r_i3 = '1;
        do_reset();

        repeat (8) cycle('1, rnd_cd(), 1'b1, 1'b0, '0, '1);
        repeat (3) cycle('0, '0, 1'b1, 1'b0, '0, '1);

        repeat (4) cycle(4'b0100, rnd_cd(), 1'b0, 1'b0, '0, '1);
        repeat (6) cycle(4'b0100, rnd_cd(), 1'b1, 1'b0, '0, '1);

        cd = rnd_cd();
        cd[2*W + LSB +: LG] = 2'd3;
        cycle(4'b0100, cd, 1'b1, 1'b0, '0, '1);
        repeat (3) cycle('0, '0, 1'b1, 1'b0, '0, '1);

        hd = rnd_w(); hd[LSB +: LG] = 2'd1;
        cycle('0, '0, 1'b1, 1'b1, hd, '1);
        hd = rnd_w(); hd[LSB +: LG] = 2'd3;
        cycle('0, '0, 1'b1, 1'b1, hd, '1);
        hd = rnd_w(); hd[LSB +: LG] = 2'd1;
        cycle('0, '0, 1'b1, 1'b1, hd, '1);
        hd = rnd_w(); hd[LSB +: LG] = 2'd2;
        repeat (3) cycle('0, '0, 1'b1, 1'b1, hd, 4'b1101);
        cycle('0, '0, 1'b1, 1'b0, hd, '1);
        repeat (2) cycle('0, '0, 1'b1, 1'b0, '0, '1);

        repeat (1500) cycle(N'($urandom()), rnd_cd(), 1'($urandom_range(0, 3) != 0),
                            1'($urandom()), rnd_w(), N'($urandom()));
        do_reset();
        repeat (500) cycle(N'($urandom()), rnd_cd(), 1'($urandom()),
                           1'($urandom()), rnd_w(), N'($urandom()));
        repeat (4) cycle('0, '0, 1'b1, 1'b0, '0, '1);
        @(negedge clk); #1;
        chk("upstream scoreboard drained", sb_up.size(), 0);

        do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        h_v3 = 1'b1; h_d3 = rnd_w(); h_d3[LSB +: LG] = 2'd3;
        @(negedge clk);
        chk("dut3 m_fsb_r_o on drop", m_r_o3, 1);
        @(posedge clk); #1;
        h_v3 = 1'b0;
        @(negedge clk);
        chk("dut3 drop_cnt_o after 1", dcnt3, 1);
        chk("dut3 drop_err_o", derr3, 1);
        chk("dut3 c_v_o after drop", c_v_o3, 0);
        @(posedge clk); #1;
        h_v3 = 1'b1;
        repeat (299) @(posedge clk);
        #1;
        h_v3 = 1'b0;
        @(negedge clk);
        chk("dut3 drop_cnt_o saturated", dcnt3, 255);
        chk("dut3 drop_err_o sticky", derr3, 1);
        chk("dut3 c_v_o after 300 drops", c_v_o3, 0);
        @(posedge clk); #1;
        h_v3 = 1'b1; hd = rnd_w(); hd[LSB +: LG] = 2'd2; h_d3 = hd; c_r_i3 = 3'b000;
        @(posedge clk); #1;
        h_v3 = 1'b0;
        @(negedge clk);
        chk("dut3 c_v_o id2", c_v_o3, 3'b100);
        chk("dut3 c_data_o id2", c_d_o3, hd);
        chk("dut3 m_fsb_r_o held", m_r_o3, 0);
        c_r_i3 = 3'b100;
        #1;
        chk("dut3 m_fsb_r_o draining", m_r_o3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
